// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory arbiter: the response-state
// encoding, the instruction width, the NOP word returned on fetch errors, and
// a saturating increment used by the optional statistics counters.
package imem_pkg;

  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  // Operation issued to the memory in the previous cycle; drives responses.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    RD_ERR = 3'd2,
    WR     = 3'd3,
    WR_ERR = 3'd4
  } rsp_state_e;

  // 32-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    logic [31:0] r;
    if (v == 32'hFFFF_FFFF) begin
      r = v;
    end else begin
      r = v + 32'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/imem_addr_chk.sv
// Byte-address (PC) checker: flags a misaligned or out-of-range address and
// extracts the word address. Shared with the data-memory arbiter.
module imem_addr_chk
  import imem_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int WORD_AW = 10
) (
  input  logic [ADDR_W-1:0]  pc,
  output logic               err,
  output logic [WORD_AW-1:0] word_addr
);

  logic misalign_s;
  logic range_s;

  // Alignment and range decode; any bit above the word index is out of range.
  always_comb begin
    misalign_s = (pc[1:0] != 2'b00);
    range_s    = |pc[ADDR_W-1:WORD_AW+2];
    err        = misalign_s | range_s;
    word_addr  = pc[WORD_AW+1:2];
  end

endmodule

// File: rtl/imem_arbiter.sv
// Arbiter sharing the single-port instruction RAM between the fetch stage and
// the program loader. The loader has priority; a burst counter caps the number
// of consecutive loader grants while a fetch waits. Responses come one cycle
// after the grant, driven from a registered response state.
// Optional statistics counters are enabled by defining IMEM_ARB_STATS_EN.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int ADDR_W       = 64,
  parameter int WORD_AW      = 10,
  parameter int MAX_LD_BURST = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_req,
  input  logic [ADDR_W-1:0]  fetch_pc,
  output logic               fetch_gnt,
  output logic               fetch_valid,
  output logic [31:0]        fetch_instr,
  output logic               fetch_err,
  input  logic               ld_req,
  input  logic [WORD_AW:0]   ld_addr,
  input  logic [31:0]        ld_data,
  output logic               ld_gnt,
  output logic               ld_ack,
  output logic               ld_err,
  output logic               mem_en,
  output logic               mem_we,
  output logic [WORD_AW-1:0] mem_addr,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata,
  output logic [31:0]        stat_fetch_stall,
  output logic [31:0]        stat_ld_writes
);

  localparam int BURST_W = $clog2(MAX_LD_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_LD_BURST);
  localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

  logic               pc_err_s;
  logic [WORD_AW-1:0] pc_word_s;
  logic               ld_oor_s;
  logic               burst_full_s;
  logic               ld_gnt_s;
  logic               fetch_gnt_s;
  logic [BURST_W-1:0] burst_cnt_r;
  rsp_state_e         rsp_r;
  rsp_state_e         rsp_nxt_s;

  imem_addr_chk #(
    .ADDR_W  (ADDR_W),
    .WORD_AW (WORD_AW)
  ) u_addr_chk (
    .pc        (fetch_pc),
    .err       (pc_err_s),
    .word_addr (pc_word_s)
  );

  assign ld_oor_s = ld_addr[WORD_AW];

  // Grant selection: loader first unless it has used up its burst allowance.
  always_comb begin
    burst_full_s = fetch_req && (burst_cnt_r == BURST_MAX);
    if (!rst_n) begin
      ld_gnt_s    = 1'b0;
      fetch_gnt_s = 1'b0;
    end else if (ld_req && !burst_full_s) begin
      ld_gnt_s    = 1'b1;
      fetch_gnt_s = 1'b0;
    end else if (fetch_req) begin
      ld_gnt_s    = 1'b0;
      fetch_gnt_s = 1'b1;
    end else begin
      ld_gnt_s    = 1'b0;
      fetch_gnt_s = 1'b0;
    end
  end

  assign ld_gnt    = ld_gnt_s;
  assign fetch_gnt = fetch_gnt_s;

  // Memory command for the granted op and the response it will produce.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {WORD_AW{1'b0}};
    mem_wdata = 32'h0000_0000;
    rsp_nxt_s = IDLE;
    if (ld_gnt_s) begin
      if (ld_oor_s) begin
        rsp_nxt_s = WR_ERR;
      end else begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ld_addr[WORD_AW-1:0];
        mem_wdata = ld_data;
        rsp_nxt_s = WR;
      end
    end else if (fetch_gnt_s) begin
      if (pc_err_s) begin
        rsp_nxt_s = RD_ERR;
      end else begin
        mem_en    = 1'b1;
        mem_addr  = pc_word_s;
        rsp_nxt_s = RD;
      end
    end else begin
      rsp_nxt_s = IDLE;
    end
  end

  // Burst counter: counts loader wins while fetch waits, cleared once fetch is served or idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt_r <= {BURST_W{1'b0}};
    end else if (!fetch_req || fetch_gnt_s) begin
      burst_cnt_r <= {BURST_W{1'b0}};
    end else if (ld_gnt_s && (burst_cnt_r != BURST_MAX)) begin
      burst_cnt_r <= burst_cnt_r + BURST_ONE;
    end else begin
      burst_cnt_r <= burst_cnt_r;
    end
  end

  // Response state: remembers which operation was issued last cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_r <= IDLE;
    end else begin
      rsp_r <= rsp_nxt_s;
    end
  end

  // Response decode; read data is passed straight through from the RAM.
  always_comb begin
    fetch_valid = 1'b0;
    fetch_err   = 1'b0;
    fetch_instr = NOP_INSTR;
    ld_ack      = 1'b0;
    ld_err      = 1'b0;
    case (rsp_r)
      IDLE: begin
        fetch_valid = 1'b0;
      end
      RD: begin
        fetch_valid = 1'b1;
        fetch_instr = mem_rdata;
      end
      RD_ERR: begin
        fetch_valid = 1'b1;
        fetch_err   = 1'b1;
      end
      WR: begin
        ld_ack = 1'b1;
      end
      WR_ERR: begin
        ld_ack = 1'b1;
        ld_err = 1'b1;
      end
      default: begin
        fetch_valid = 1'b0;
      end
    endcase
  end

`ifdef IMEM_ARB_STATS_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] ldw_cnt_r;

  // Saturating counters: fetch stall cycles and successful loader writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= 32'h0000_0000;
      ldw_cnt_r   <= 32'h0000_0000;
    end else begin
      if (fetch_req && !fetch_gnt_s) begin
        stall_cnt_r <= sat_inc32(stall_cnt_r);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (rsp_r == WR) begin
        ldw_cnt_r <= sat_inc32(ldw_cnt_r);
      end else begin
        ldw_cnt_r <= ldw_cnt_r;
      end
    end
  end

  assign stat_fetch_stall = stall_cnt_r;
  assign stat_ld_writes   = ldw_cnt_r;
`else
  assign stat_fetch_stall = 32'h0000_0000;
  assign stat_ld_writes   = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_imem_arbiter;

  localparam int ADDR_W       = 64;
  localparam int WORD_AW      = 10;
  localparam int MAX_LD_BURST = 8;
  localparam int DEPTH        = 1024;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               fetch_req;
  logic [ADDR_W-1:0]  fetch_pc;
  logic               fetch_gnt;
  logic               fetch_valid;
  logic [31:0]        fetch_instr;
  logic               fetch_err;
  logic               ld_req;
  logic [WORD_AW:0]   ld_addr;
  logic [31:0]        ld_data;
  logic               ld_gnt;
  logic               ld_ack;
  logic               ld_err;
  logic               mem_en;
  logic               mem_we;
  logic [WORD_AW-1:0] mem_addr;
  logic [31:0]        mem_wdata;
  logic [31:0]        mem_rdata = 32'h0;
  logic [31:0]        stat_fetch_stall;
  logic [31:0]        stat_ld_writes;

  int checks = 0;
  int failures = 0;

  // RAM macro stand-in (environment) and golden memory (reference model).
  logic [31:0] ram     [0:DEPTH-1] = '{default: 32'h0};
  logic [31:0] ref_mem [0:DEPTH-1] = '{default: 32'h0};

  // Reference model state
  int          m_burst;
  bit          p_rd, p_rd_err, p_wr, p_wr_err;
  logic [31:0] p_instr;
  logic [31:0] m_stall, m_ldw;
  bit          m_ld_gnt, m_f_gnt;
  bit          obs_ld_gnt, obs_f_gnt;

  imem_arbiter #(
    .ADDR_W(ADDR_W), .WORD_AW(WORD_AW), .MAX_LD_BURST(MAX_LD_BURST)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_gnt(fetch_gnt),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_err(fetch_err),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_gnt(ld_gnt),
    .ld_ack(ld_ack), .ld_err(ld_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .stat_fetch_stall(stat_fetch_stall), .stat_ld_writes(stat_ld_writes)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM behaviour
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_burst = 0;
    p_rd = 0; p_rd_err = 0; p_wr = 0; p_wr_err = 0; p_instr = 32'h0;
    m_stall = 32'h0; m_ldw = 32'h0;
  endtask

  // One clock cycle: inputs already driven; checks grants/memory command,
  // advances the clock, then checks responses. Optionally resets after the edge.
  task automatic cycle(input bit rst_after);
    bit f_err, ld_oor, e_en, e_we, nxt_rd, nxt_rd_err, nxt_wr, nxt_wr_err, stall_inc;
    int f_word, l_word;
    logic [31:0] e_addr, e_wd, nxt_instr, e_stall, e_ldw;
    #2;
    f_err  = ((fetch_pc % 4) != 0) || ((fetch_pc >> 2) >= 64'd1024);
    f_word = int'((fetch_pc >> 2) % 64'd1024);
    ld_oor = (ld_addr >= 11'd1024);
    l_word = int'(ld_addr % 11'd1024);
    m_ld_gnt = rst_n && ld_req && !(fetch_req && m_burst == MAX_LD_BURST);
    m_f_gnt  = rst_n && fetch_req && !m_ld_gnt;
    obs_ld_gnt = ld_gnt; obs_f_gnt = fetch_gnt;
    chk("ld_gnt", ld_gnt, m_ld_gnt);
    chk("fetch_gnt", fetch_gnt, m_f_gnt);
    e_en = 0; e_we = 0; e_addr = 0; e_wd = 0;
    if (m_ld_gnt && !ld_oor) begin
      e_en = 1; e_we = 1; e_addr = l_word; e_wd = ld_data;
    end else if (m_f_gnt && !f_err) begin
      e_en = 1; e_addr = f_word;
    end
    chk("mem_en", mem_en, e_en);
    chk("mem_we", mem_we, e_we);
    if (e_en) chk("mem_addr", mem_addr, e_addr);
    else chk("mem_addr_idle", mem_addr, 0);
    if (e_we || !e_en) chk("mem_wdata", mem_wdata, e_wd);
    nxt_rd     = m_f_gnt && !f_err;
    nxt_rd_err = m_f_gnt && f_err;
    nxt_instr  = nxt_rd ? ref_mem[f_word] : 32'h0;
    nxt_wr     = m_ld_gnt && !ld_oor;
    nxt_wr_err = m_ld_gnt && ld_oor;
    stall_inc  = fetch_req && !m_f_gnt;
    @(posedge clk);
    if (rst_n) begin
      if (p_wr && m_ldw != 32'hFFFF_FFFF) m_ldw++;
      if (stall_inc && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (nxt_wr) ref_mem[l_word] = ld_data;
      if (!fetch_req || m_f_gnt) m_burst = 0;
      else if (m_ld_gnt && m_burst < MAX_LD_BURST) m_burst++;
      p_rd = nxt_rd; p_rd_err = nxt_rd_err; p_instr = nxt_instr;
      p_wr = nxt_wr; p_wr_err = nxt_wr_err;
    end else begin
      model_clear();
    end
    #1;
    if (rst_after) begin
      rst_n = 1'b0;
      model_clear();
      #1;
    end
    chk("fetch_valid", fetch_valid, p_rd || p_rd_err);
    chk("fetch_err", fetch_err, p_rd_err);
    chk("fetch_instr", fetch_instr, p_rd ? p_instr : 32'h0);
    chk("ld_ack", ld_ack, p_wr || p_wr_err);
    chk("ld_err", ld_err, p_wr_err);
`ifdef IMEM_ARB_STATS_EN
    e_stall = m_stall; e_ldw = m_ldw;
`else
    e_stall = 32'h0; e_ldw = 32'h0;
`endif
    chk("stat_fetch_stall", stat_fetch_stall, e_stall);
    chk("stat_ld_writes", stat_ld_writes, e_ldw);
  endtask

  function automatic logic [63:0] rand_pc();
    int unsigned r = $urandom_range(0, 9);
    logic [63:0] w = 64'($urandom_range(0, 15));
    if (r == 0) return (w << 2) | 64'($urandom_range(1, 3));
    else if (r == 1) return {32'($urandom), 32'h0} | (w << 2);
    else if (r == 2) return 64'h1000 + (w << 2);
    else return w << 2;
  endfunction

  function automatic logic [WORD_AW:0] rand_ld();
    logic [WORD_AW-1:0] w = WORD_AW'($urandom_range(0, 15));
    if ($urandom_range(0, 5) == 0) return {1'b1, w};
    else return {1'b0, w};
  endfunction

  initial begin
    int n_ld, n_f, first_f;
    rst_n = 1'b0; fetch_req = 0; fetch_pc = 64'h0; ld_req = 0; ld_addr = 11'h0; ld_data = 32'h0;
    model_clear();
    #1;
    // Reset state, including requests held high during reset
    cycle(0);
    fetch_req = 1; ld_req = 1;
    cycle(0);
    fetch_req = 0; ld_req = 0;
    rst_n = 1'b1;
    cycle(0);

    // 1: loader write word 0, then fetch PC 0
    ld_req = 1; ld_addr = 11'h000; ld_data = 32'h8b1f03e5;
    cycle(0);
    chk("t1_ld_ack", ld_ack, 1'b1);
    ld_req = 0; fetch_req = 1; fetch_pc = 64'h0;
    cycle(0);
    chk("t1_instr", fetch_instr, 32'h8b1f03e5);
    fetch_req = 0;

    // 2: write word 2 at N, fetch PC 8 at N+1
    ld_req = 1; ld_addr = 11'h002; ld_data = 32'hf84000a4;
    cycle(0);
    ld_req = 0; fetch_req = 1; fetch_pc = 64'h8;
    cycle(0);
    chk("t2_instr", fetch_instr, 32'hf84000a4);
    fetch_req = 0;
    cycle(0);

    // 3: burst limit with both requesters held
    n_ld = 0; n_f = 0; first_f = 0;
    fetch_req = 1; fetch_pc = 64'h0; ld_req = 1; ld_addr = 11'h005;
    for (int i = 1; i <= 20; i++) begin
      ld_data = 32'h5a00_0000 + 32'(i);
      cycle(0);
      if (obs_ld_gnt) n_ld++;
      if (obs_f_gnt) begin
        n_f++;
        if (first_f == 0) first_f = i;
      end
    end
    chk("t3_ld_grants", 64'(n_ld), 64'd18);
    chk("t3_fetch_grants", 64'(n_f), 64'd2);
    chk("t3_first_fetch", 64'(first_f), 64'd9);
    fetch_req = 0; ld_req = 0;
    cycle(0);

    // 4: erroneous fetches and out-of-range loader write
    fetch_req = 1; fetch_pc = 64'h6;
    cycle(0);
    chk("t4_err_pc6", fetch_err, 1'b1);
    fetch_pc = 64'h1000;
    cycle(0);
    chk("t4_err_pc1000", fetch_err, 1'b1);
    fetch_req = 0; ld_req = 1; ld_addr = 11'h400; ld_data = 32'hdeadbeef;
    cycle(0);
    chk("t4_ld_err", ld_err, 1'b1);
    ld_req = 0; fetch_req = 1; fetch_pc = 64'h0;
    cycle(0);
    chk("t4_no_alias_write", fetch_instr, 32'h8b1f03e5);
    fetch_req = 0;

    // 5: reset right after a fetch grant
    ld_req = 1; ld_addr = 11'h001; ld_data = 32'h1234abcd;
    cycle(0);
    ld_req = 0; fetch_req = 1; fetch_pc = 64'h4;
    cycle(1);
    chk("t5_valid_dropped", fetch_valid, 1'b0);
    ld_req = 1;
    cycle(0);
    ld_req = 0;
    rst_n = 1'b1;
    cycle(0);
    chk("t5_instr_after_reset", fetch_instr, 32'h1234abcd);
    fetch_req = 0;

    // Randomized traffic honouring hold-until-grant
    for (int i = 0; i < 600; i++) begin
      if (!fetch_req || m_f_gnt) begin
        fetch_req = ($urandom_range(0, 3) != 0);
        fetch_pc  = rand_pc();
      end
      if (!ld_req || m_ld_gnt) begin
        ld_req  = ($urandom_range(0, 2) != 0);
        ld_addr = rand_ld();
        ld_data = $urandom;
      end
      cycle(0);
    end
    fetch_req = 0; ld_req = 0;
    cycle(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
Shares the single-port synchronous instruction memory between the CPU fetch stage and the program loader (debug/boot path that writes instruction words). Issues at most one memory operation per cycle. The loader has priority, and a bounded burst counter keeps fetch from starving. Sits between the fetch stage/loader and the IM RAM macro; fetch sees a 1-cycle-latency valid/data response.

Parameters:
ADDR_W, 64, fetch byte-address (PC) width
WORD_AW, 10, memory word-address width; depth = 2**WORD_AW words
MAX_LD_BURST, 8, max consecutive loader grants while fetch_req is pending

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
fetch_req  in  1  fetch request; held with fetch_pc stable until fetch_gnt
fetch_pc  in  ADDR_W  byte address of instruction
fetch_gnt  out  1  request accepted this cycle (combinational)
fetch_valid  out  1  response valid, one cycle after grant
fetch_instr  out  32  instruction word (0 when fetch_err)
fetch_err  out  1  misaligned or out-of-range PC
ld_req  in  1  loader write request; held stable until ld_gnt
ld_addr  in  WORD_AW+1  word address (MSB set = out of range)
ld_data  in  32  word to write
ld_gnt  out  1  write accepted this cycle (combinational)
ld_ack  out  1  write completed, one cycle after grant
ld_err  out  1  with ld_ack: address out of range, no write performed
mem_en  out  1  memory enable
mem_we  out  1  write enable
mem_addr  out  WORD_AW  word address
mem_wdata  out  32  write data
mem_rdata  in  32  read data, valid cycle after mem_en & !mem_we
stat_fetch_stall  out  32  stats (see Optional Feature)
stat_ld_writes  out  32  stats (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): fetch_valid, fetch_err, ld_ack, ld_err = 0; fetch_instr = 0; burst counter = 0; response state = IDLE. Any in-flight read or write response is dropped. A write whose mem_en was sampled before reset is not rolled back.
- Response state register (IDLE/RD/RD_ERR/WR/WR_ERR) records the op issued last cycle and drives the responses:
  - RD: fetch_valid=1, fetch_instr=mem_rdata.
  - RD_ERR: fetch_valid=1, fetch_err=1, instr=0.
  - WR/WR_ERR: ld_ack=1, with ld_err set for WR_ERR.
- Arbitration each cycle:
  - Loader granted if ld_req, unless fetch_req && burst_cnt==MAX_LD_BURST.
  - Otherwise fetch granted if fetch_req.
  - Never both granted in the same cycle.
- burst_cnt: increments on each loader grant while fetch_req=1 (saturates at MAX_LD_BURST); clears on fetch grant or whenever fetch_req=0.
- Fetch address check:
  - PC[1:0]!=0, or PC>>2 >= 2**WORD_AW, gives error.
  - Granted erroneous fetch: no mem_en; RD_ERR next cycle.
  - Otherwise mem_en=1, mem_we=0, mem_addr=PC[WORD_AW+1:2].
- Loader grant:
  - ld_addr MSB set: no mem_en; WR_ERR next.
  - Otherwise mem_en=mem_we=1, mem_wdata=ld_data.
- Back-to-back operations allowed every cycle; throughput 1 op/cycle.
- Write to word X in cycle N followed by fetch of X in N+1 must return the new data. RAM read-after-write across cycles is guaranteed by the macro; the arbiter adds no bypass.
- mem_addr/mem_wdata are don't-care when mem_en=0 and are driven 0.
- No grant while rst_n=0.

Optional Feature:
IMEM_ARB_STATS_EN.
- Defined: stat_fetch_stall counts cycles with fetch_req=1 && fetch_gnt=0. stat_ld_writes counts successful loader writes (ld_ack && !ld_err). Both are 32-bit, saturating at 0xFFFFFFFF, cleared by reset.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Shared package imem_pkg: response-state enum (IDLE, RD, RD_ERR, WR, WR_ERR), INSTR_W=32 constant, NOP instruction constant (0).
- One sub-module, imem_addr_chk: combinational PC alignment/range check producing err and word address. Reused later by the data-memory arbiter.

Test Plan:
1. Loader writes 0x8b1f03e5 to word 0, then fetch PC=0x0 -> ld_ack the cycle after ld_gnt; fetch_valid one cycle after fetch_gnt with instr 0x8b1f03e5, err=0.
2. Loader write 0xf84000a4 to word 2 at cycle N, fetch PC=0x8 granted at N+1 -> instr 0xf84000a4 at N+2.
3. MAX_LD_BURST=8, ld_req and fetch_req held high for 20 cycles -> 8 loader grants, 1 fetch grant on the 9th cycle, pattern repeats; stat_fetch_stall=8 after first fetch grant (STATS_EN).
4. Fetch PC=0x6 and PC=0x1000 (WORD_AW=10) -> no mem_en; fetch_valid=1, fetch_err=1, instr=0 next cycle. ld_addr=0x400 -> ld_ack=1, ld_err=1, no write.
5. Assert rst_n=0 in the cycle after a fetch grant -> fetch_valid stays 0, all outputs 0; after release, fetch PC=0x4 returns the stored word normally.
